load_store_queue: RTL and testbench

- In-order circular queue of memory operations, directly upstream of the dmem read/write unit.
- Accepts dispatched loads and stores and captures missing operands from the CDB.
- Computes the effective address of the head entry.
- Presents the head entry to the dmem read/write unit, which pops it with lsu_read_i.
- Tracks speculation under one outstanding branch, so that squashed entries are popped and dropped downstream.

---
 rtl/load_store_queue.sv | 276 +++++++++++++++++++++++++++
 tb/tb_load_store_queue.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : load_store_queue (with lsq_pkg)
//  Purpose  : In-order circular queue of memory operations sitting directly
//             upstream of the dmem read/write unit. Captures missing operands
//             from the CDB, computes the head effective address, and tracks
//             speculation under a single outstanding branch.
//  Ports    :
//    clk_i, reset_i          clock, asynchronous active-high reset
//    enq_*                   dispatch interface (valid/ready plus operands)
//    cdb_i                   common data bus (tag, val); tag NO_VAL = idle
//    br_resolve_i/correct_i  outstanding branch resolution
//    lsu_read_i              downstream pop of the head entry
//    lsu_*_o                 head entry presentation to the dmem unit
//  Revision : 1.0  initial release
// ============================================================================

package lsq_pkg;
  localparam int TAG_W = 6;
  typedef logic [TAG_W-1:0] rs_tag_t;
  // Tag value meaning "no producer outstanding, the value field is valid".
  localparam rs_tag_t NO_VAL = '0;
  typedef struct packed {
    rs_tag_t     tag;
    logic [31:0] val;
  } cdb_t;
endpackage

module load_store_queue
  import lsq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enq_valid_i,
  output logic        enq_ready_o,
  input  logic        enq_load_i,
  input  rs_tag_t     enq_base_tag_i,
  input  logic [31:0] enq_base_val_i,
  input  logic [31:0] enq_offset_i,
  input  rs_tag_t     enq_data_tag_i,
  input  logic [31:0] enq_data_val_i,
  input  rs_tag_t     enq_ld_tag_i,
  input  logic        enq_spec_i,
  input  cdb_t        cdb_i,
  input  logic        br_resolve_i,
  input  logic        br_correct_i,
  input  logic        lsu_read_i,
  output logic        lsu_empty_o,
  output logic [31:0] lsu_eff_addr_o,
  output logic [31:0] lsu_st_data_o,
  output rs_tag_t     lsu_ld_tag_o,
  output logic        lsu_load_o,
  output logic        lsu_instr_ready_o,
  output logic        lsu_specultative_o,
  output logic        lsu_corr_pred_o
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = c_ptr_w + 1;

  typedef logic [c_ptr_w-1:0] ptr_t;
  typedef logic [c_cnt_w-1:0] cnt_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  cnt_t count_q, count_d;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] load_q, load_d;
  logic [DEPTH-1:0] spec_q, spec_d;
  logic [DEPTH-1:0] squash_q, squash_d;

  rs_tag_t     base_tag_q [DEPTH];
  rs_tag_t     base_tag_d [DEPTH];
  logic [31:0] base_val_q [DEPTH];
  logic [31:0] base_val_d [DEPTH];
  logic [31:0] offset_q   [DEPTH];
  logic [31:0] offset_d   [DEPTH];
  rs_tag_t     data_tag_q [DEPTH];
  rs_tag_t     data_tag_d [DEPTH];
  logic [31:0] data_val_q [DEPTH];
  logic [31:0] data_val_d [DEPTH];
  rs_tag_t     ld_tag_q   [DEPTH];
  rs_tag_t     ld_tag_d   [DEPTH];

  // --------------------------------------------------------------------------
  // Handshakes
  // --------------------------------------------------------------------------
  logic cdb_live;
  logic enq_fire;
  logic pop_fire;
  logic head_valid;

  assign cdb_live    = (cdb_i.tag != NO_VAL);
  // Readiness looks only at the registered count, so a same-cycle pop never
  // opens a slot for a same-cycle enqueue.
  assign enq_ready_o = (count_q != cnt_t'(DEPTH));
  assign enq_fire    = enq_valid_i & enq_ready_o;
  assign lsu_empty_o = (count_q == '0);
  assign head_valid  = valid_q[head_q] & ~lsu_empty_o;
  assign pop_fire    = lsu_read_i & ~lsu_empty_o & lsu_instr_ready_o;

  // --------------------------------------------------------------------------
  // Enqueue operand bypass: a tag broadcast on the CDB in the same cycle as
  // dispatch is stored already captured, otherwise it would be missed.
  // --------------------------------------------------------------------------
  rs_tag_t     enq_base_tag;
  logic [31:0] enq_base_val;
  rs_tag_t     enq_data_tag;
  logic [31:0] enq_data_val;

  always_comb begin
    enq_base_tag = enq_base_tag_i;
    enq_base_val = enq_base_val_i;
    enq_data_tag = enq_data_tag_i;
    enq_data_val = enq_data_val_i;
    if (cdb_live && (enq_base_tag_i == cdb_i.tag)) begin
      enq_base_tag = NO_VAL;
      enq_base_val = cdb_i.val;
    end
    if (enq_load_i) begin
      // Loads carry no store data; never let them wait on it.
      enq_data_tag = NO_VAL;
    end else if (cdb_live && (enq_data_tag_i == cdb_i.tag)) begin
      enq_data_tag = NO_VAL;
      enq_data_val = cdb_i.val;
    end
  end

  // --------------------------------------------------------------------------
  // Per-entry next state
  // --------------------------------------------------------------------------
  always_comb begin
    valid_d    = valid_q;
    load_d     = load_q;
    spec_d     = spec_q;
    squash_d   = squash_q;
    base_tag_d = base_tag_q;
    base_val_d = base_val_q;
    offset_d   = offset_q;
    data_tag_d = data_tag_q;
    data_val_d = data_val_q;
    ld_tag_d   = ld_tag_q;

    for (int i = 0; i < DEPTH; i++) begin
      // Operand capture from the CDB.
      if (valid_q[i] && cdb_live) begin
        if (base_tag_q[i] == cdb_i.tag) begin
          base_tag_d[i] = NO_VAL;
          base_val_d[i] = cdb_i.val;
        end
        if (data_tag_q[i] == cdb_i.tag) begin
          data_tag_d[i] = NO_VAL;
          data_val_d[i] = cdb_i.val;
        end
      end

      // Branch resolution; the entry leaving this cycle is left alone.
      if (valid_q[i] && br_resolve_i && !(pop_fire && (ptr_t'(i) == head_q))) begin
        if (br_correct_i) begin
          spec_d[i] = 1'b0;
        end else if (spec_q[i]) begin
          squash_d[i] = 1'b1;
        end
      end

      // Pop invalidates the head slot.
      if (pop_fire && (ptr_t'(i) == head_q)) begin
        valid_d[i]  = 1'b0;
        spec_d[i]   = 1'b0;
        squash_d[i] = 1'b0;
      end

      // Enqueue writes the tail slot. It cannot alias the popped slot: head
      // equals tail only when the queue is empty (no pop) or full (no enq).
      if (enq_fire && (ptr_t'(i) == tail_q)) begin
        valid_d[i]    = 1'b1;
        load_d[i]     = enq_load_i;
        spec_d[i]     = enq_spec_i;
        squash_d[i]   = 1'b0;
        base_tag_d[i] = enq_base_tag;
        base_val_d[i] = enq_base_val;
        offset_d[i]   = enq_offset_i;
        data_tag_d[i] = enq_data_tag;
        data_val_d[i] = enq_data_val;
        ld_tag_d[i]   = enq_ld_tag_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pointers and occupancy (power-of-two depth, pointers wrap naturally)
  // --------------------------------------------------------------------------
  always_comb begin
    head_d  = pop_fire ? (head_q + ptr_t'(1)) : head_q;
    tail_d  = enq_fire ? (tail_q + ptr_t'(1)) : tail_q;
    count_d = count_q;
    case ({enq_fire, pop_fire})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      load_q   <= '0;
      spec_q   <= '0;
      squash_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        base_tag_q[i] <= NO_VAL;
        base_val_q[i] <= '0;
        offset_q[i]   <= '0;
        data_tag_q[i] <= NO_VAL;
        data_val_q[i] <= '0;
        ld_tag_q[i]   <= NO_VAL;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      load_q     <= load_d;
      spec_q     <= spec_d;
      squash_q   <= squash_d;
      base_tag_q <= base_tag_d;
      base_val_q <= base_val_d;
      offset_q   <= offset_d;
      data_tag_q <= data_tag_d;
      data_val_q <= data_val_d;
      ld_tag_q   <= ld_tag_d;
    end
  end

  // --------------------------------------------------------------------------
  // Head presentation. A squashed head is ready regardless of operands so it
  // can drain; an unsquashed speculative head waits for the branch.
  // --------------------------------------------------------------------------
  always_comb begin
    lsu_eff_addr_o     = '0;
    lsu_st_data_o      = '0;
    lsu_ld_tag_o       = NO_VAL;
    lsu_load_o         = 1'b0;
    lsu_instr_ready_o  = 1'b0;
    lsu_specultative_o = 1'b0;
    lsu_corr_pred_o    = 1'b1;
    if (head_valid) begin
      lsu_eff_addr_o     = base_val_q[head_q] + offset_q[head_q];
      lsu_st_data_o      = data_val_q[head_q];
      lsu_ld_tag_o       = ld_tag_q[head_q];
      lsu_load_o         = load_q[head_q];
      lsu_specultative_o = spec_q[head_q];
      lsu_corr_pred_o    = ~squash_q[head_q];
      lsu_instr_ready_o  = squash_q[head_q] |
                           (~spec_q[head_q] &
                            (base_tag_q[head_q] == NO_VAL) &
                            (load_q[head_q] | (data_tag_q[head_q] == NO_VAL)));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_queue
//  Purpose  : Self-checking bench for load_store_queue. A queue-of-records
//             reference model follows the dispatch/CDB/branch/pop rules; a
//             monitor compares the DUT head presentation to the model front.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_store_queue;
  import lsq_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        enq_valid_i;
  logic        enq_ready_o;
  logic        enq_load_i;
  rs_tag_t     enq_base_tag_i;
  logic [31:0] enq_base_val_i;
  logic [31:0] enq_offset_i;
  rs_tag_t     enq_data_tag_i;
  logic [31:0] enq_data_val_i;
  rs_tag_t     enq_ld_tag_i;
  logic        enq_spec_i;
  cdb_t        cdb_i;
  logic        br_resolve_i;
  logic        br_correct_i;
  logic        lsu_read_i;
  logic        lsu_empty_o;
  logic [31:0] lsu_eff_addr_o;
  logic [31:0] lsu_st_data_o;
  rs_tag_t     lsu_ld_tag_o;
  logic        lsu_load_o;
  logic        lsu_instr_ready_o;
  logic        lsu_specultative_o;
  logic        lsu_corr_pred_o;

  load_store_queue #(.DEPTH(DEPTH)) dut (
    .clk_i              (clk),
    .reset_i            (reset_i),
    .enq_valid_i        (enq_valid_i),
    .enq_ready_o        (enq_ready_o),
    .enq_load_i         (enq_load_i),
    .enq_base_tag_i     (enq_base_tag_i),
    .enq_base_val_i     (enq_base_val_i),
    .enq_offset_i       (enq_offset_i),
    .enq_data_tag_i     (enq_data_tag_i),
    .enq_data_val_i     (enq_data_val_i),
    .enq_ld_tag_i       (enq_ld_tag_i),
    .enq_spec_i         (enq_spec_i),
    .cdb_i              (cdb_i),
    .br_resolve_i       (br_resolve_i),
    .br_correct_i       (br_correct_i),
    .lsu_read_i         (lsu_read_i),
    .lsu_empty_o        (lsu_empty_o),
    .lsu_eff_addr_o     (lsu_eff_addr_o),
    .lsu_st_data_o      (lsu_st_data_o),
    .lsu_ld_tag_o       (lsu_ld_tag_o),
    .lsu_load_o         (lsu_load_o),
    .lsu_instr_ready_o  (lsu_instr_ready_o),
    .lsu_specultative_o (lsu_specultative_o),
    .lsu_corr_pred_o    (lsu_corr_pred_o)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: an ordered list of outstanding operations.
  // --------------------------------------------------------------------------
  typedef struct {
    logic        ld;
    rs_tag_t     btag;
    logic [31:0] bval;
    logic [31:0] off;
    rs_tag_t     dtag;
    logic [31:0] dval;
    rs_tag_t     ltag;
    logic        spec;
    logic        sq;
  } ent_t;

  ent_t m_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic m_ready();
    if (m_q.size() == 0) return 1'b0;
    return m_q[0].sq ||
           (!m_q[0].spec && m_q[0].btag == NO_VAL &&
            (m_q[0].ld || m_q[0].dtag == NO_VAL));
  endfunction

  always @(posedge clk or posedge reset_i) begin : model
    logic do_pop;
    logic do_enq;
    ent_t e;
    if (reset_i) begin
      m_q.delete();
    end else begin
      do_pop = lsu_read_i && m_ready();
      do_enq = enq_valid_i && (m_q.size() < DEPTH);
      if (do_pop) void'(m_q.pop_front());
      for (int i = 0; i < m_q.size(); i++) begin
        e = m_q[i];
        if (cdb_i.tag != NO_VAL && e.btag == cdb_i.tag) begin
          e.btag = NO_VAL; e.bval = cdb_i.val;
        end
        if (cdb_i.tag != NO_VAL && e.dtag == cdb_i.tag) begin
          e.dtag = NO_VAL; e.dval = cdb_i.val;
        end
        if (br_resolve_i) begin
          if (br_correct_i) e.spec = 1'b0;
          else if (e.spec) e.sq = 1'b1;
        end
        m_q[i] = e;
      end
      if (do_enq) begin
        e.ld = enq_load_i; e.off = enq_offset_i; e.ltag = enq_ld_tag_i;
        e.spec = enq_spec_i; e.sq = 1'b0;
        e.btag = enq_base_tag_i; e.bval = enq_base_val_i;
        e.dtag = enq_data_tag_i; e.dval = enq_data_val_i;
        if (cdb_i.tag != NO_VAL && e.btag == cdb_i.tag) begin
          e.btag = NO_VAL; e.bval = cdb_i.val;
        end
        if (enq_load_i) e.dtag = NO_VAL;
        else if (cdb_i.tag != NO_VAL && e.dtag == cdb_i.tag) begin
          e.dtag = NO_VAL; e.dval = cdb_i.val;
        end
        m_q.push_back(e);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: samples 1ns after each falling clock edge and after reset rises.
  // --------------------------------------------------------------------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    ent_t h;
    forever begin
      @(negedge clk or posedge reset_i);
      #1;
      chk("enq_ready", {31'd0, enq_ready_o}, {31'd0, m_q.size() < DEPTH});
      if (m_q.size() == 0) begin
        chk("empty", {31'd0, lsu_empty_o}, 32'd1);
        chk("ready_empty", {31'd0, lsu_instr_ready_o}, 32'd0);
        chk("load_empty", {31'd0, lsu_load_o}, 32'd0);
        chk("spec_empty", {31'd0, lsu_specultative_o}, 32'd0);
        chk("corr_empty", {31'd0, lsu_corr_pred_o}, 32'd1);
        chk("addr_empty", lsu_eff_addr_o, 32'd0);
        chk("data_empty", lsu_st_data_o, 32'd0);
        chk("ldtag_empty", {26'd0, lsu_ld_tag_o}, 32'd0);
      end else begin
        h = m_q[0];
        chk("empty", {31'd0, lsu_empty_o}, 32'd0);
        chk("instr_ready", {31'd0, lsu_instr_ready_o}, {31'd0, m_ready()});
        chk("load", {31'd0, lsu_load_o}, {31'd0, h.ld});
        chk("spec", {31'd0, lsu_specultative_o}, {31'd0, h.spec});
        chk("corr_pred", {31'd0, lsu_corr_pred_o}, {31'd0, ~h.sq});
        if (h.btag == NO_VAL) chk("eff_addr", lsu_eff_addr_o, h.bval + h.off);
        if (!h.ld && h.dtag == NO_VAL) chk("st_data", lsu_st_data_o, h.dval);
        if (h.ld) chk("ld_tag", {26'd0, lsu_ld_tag_o}, {26'd0, h.ltag});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic idle();
    enq_valid_i = 1'b0; enq_load_i = 1'b0; enq_spec_i = 1'b0;
    enq_base_tag_i = NO_VAL; enq_base_val_i = '0; enq_offset_i = '0;
    enq_data_tag_i = NO_VAL; enq_data_val_i = '0; enq_ld_tag_i = NO_VAL;
    cdb_i = '0; br_resolve_i = 1'b0; br_correct_i = 1'b0; lsu_read_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic ld, input rs_tag_t bt, input logic [31:0] bv,
                     input logic [31:0] off, input rs_tag_t dt, input logic [31:0] dv,
                     input rs_tag_t lt, input logic sp);
    enq_valid_i = 1'b1; enq_load_i = ld; enq_base_tag_i = bt; enq_base_val_i = bv;
    enq_offset_i = off; enq_data_tag_i = dt; enq_data_val_i = dv;
    enq_ld_tag_i = lt; enq_spec_i = sp;
  endtask

  task automatic drain(input int n);
    idle();
    for (int k = 0; k < n; k++) begin
      cdb_i = {rs_tag_t'((k % 15) + 1), $urandom};
      br_resolve_i = (k % 4 == 0);
      br_correct_i = 1'b1;
      lsu_read_i = m_ready();
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    reset_i = 1'b1;
    repeat (2) step();
    reset_i = 1'b0;
    step();

    // Load with resolved base; negative offset wraps below base.
    enq(1'b1, NO_VAL, 32'h0000_1000, 32'hFFFF_FFFC, NO_VAL, 32'h0, 6'd3, 1'b0);
    step(); idle();
    lsu_read_i = m_ready();
    step(); idle(); step();

    // Store waiting on data tag 5, then captured from the CDB.
    enq(1'b0, NO_VAL, 32'h0000_0200, 32'h10, 6'd5, 32'h0, NO_VAL, 1'b0);
    step(); idle(); step();
    cdb_i = {6'd5, 32'hDEAD_BEEF};
    step(); idle();
    lsu_read_i = m_ready();
    step(); idle();
    // Same-cycle CDB bypass at enqueue.
    enq(1'b0, NO_VAL, 32'h0000_0300, 32'h4, 6'd6, 32'h0, NO_VAL, 1'b0);
    cdb_i = {6'd6, 32'hCAFE_F00D};
    step(); idle();
    lsu_read_i = m_ready();
    step(); idle();

    // Fill to capacity, then enqueue and pop together while full.
    for (int i = 0; i < DEPTH; i++) begin
      enq(1'b1, NO_VAL, 32'h100 * i, 32'h8, NO_VAL, 32'h0, rs_tag_t'(i + 1), 1'b0);
      step();
    end
    idle();
    enq(1'b1, NO_VAL, 32'h9999, 32'h1, NO_VAL, 32'h0, 6'd40, 1'b0);
    lsu_read_i = m_ready();
    step(); idle(); step();
    drain(10);

    // Wrap-around: 20 enqueue/pop pairs.
    for (int i = 0; i < 20; i++) begin
      enq(1'b1, NO_VAL, $urandom, $urandom, NO_VAL, 32'h0, rs_tag_t'(i + 1), 1'b0);
      lsu_read_i = m_ready();
      step();
    end
    drain(4);

    // Two speculative loads with pending bases, then mispredict.
    enq(1'b1, 6'd9, 32'h0, 32'h40, NO_VAL, 32'h0, 6'd7, 1'b1);
    step();
    enq(1'b1, 6'd10, 32'h0, 32'h44, NO_VAL, 32'h0, 6'd8, 1'b1);
    step(); idle(); step();
    br_resolve_i = 1'b1; br_correct_i = 1'b0;
    step(); idle();
    for (int i = 0; i < 3; i++) begin
      lsu_read_i = m_ready();
      step();
    end
    idle(); step();

    // Speculative store stalls until a correct resolution.
    enq(1'b0, NO_VAL, 32'h500, 32'h8, NO_VAL, 32'h1234, NO_VAL, 1'b1);
    step(); idle(); step(); step();
    br_resolve_i = 1'b1; br_correct_i = 1'b1;
    step(); idle();
    for (int i = 0; i < 3; i++) begin
      enq(1'b1, 6'd12, 32'h0, 32'h0, NO_VAL, 32'h0, rs_tag_t'(i + 20), 1'b0);
      step();
    end
    idle();
    // Asynchronous reset mid-queue, away from any clock edge.
    #1 reset_i = 1'b1;
    #3;
    @(posedge clk); #1;
    reset_i = 1'b0;
    step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      idle();
      if ($urandom_range(0, 99) < 60) begin
        enq($urandom_range(0, 1) == 1,
            ($urandom_range(0, 1) == 1) ? NO_VAL : rs_tag_t'($urandom_range(1, 7)),
            $urandom, $urandom,
            ($urandom_range(0, 1) == 1) ? NO_VAL : rs_tag_t'($urandom_range(1, 7)),
            $urandom, rs_tag_t'($urandom_range(0, 63)),
            $urandom_range(0, 9) < 3);
      end
      cdb_i = {rs_tag_t'($urandom_range(0, 7)), $urandom};
      br_resolve_i = ($urandom_range(0, 15) == 0);
      br_correct_i = ($urandom_range(0, 1) == 1);
      lsu_read_i = m_ready() && ($urandom_range(0, 3) != 0);
      step();
    end
    drain(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
